sqrt_pipe_hs: RTL and testbench
===============================

# sqrt_pipe_hs

Parametrised, fully pipelined unsigned integer square root with a valid/ready handshake on both sides, so downstream backpressure stalls the pipe without losing data. It also provides a remainder output, a tag that travels with each operand, an optional round-to-nearest mode, and a configurable number of root bits resolved per pipeline stage. It is the drop-in successor to the fixed one-bit-per-stage, free-running square-root pipe used in the datapath, and sits between an operand producer and a consumer that may stall.

## Interface
- WIDTH_IN, 16: radicand width, ≥ 2.
- WIDTH_OUT, WIDTH_IN/2 + WIDTH_IN%2: root width.
- ITER_PER_STAGE, 1: root bits resolved per register stage, 1..WIDTH_OUT.
- TAG_WIDTH, 4: sideband tag width, ≥ 1.
- ROUND, 0: 0 selects floor root, 1 selects round-to-nearest root.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand present.
- in_ready  out  1  pipe accepts the operand this cycle.
- in_radicand  in  WIDTH_IN  unsigned radicand.
- in_tag  in  TAG_WIDTH  carried unchanged to out_tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_root  out  WIDTH_OUT  root.
- out_rem  out  WIDTH_OUT+1  radicand − floor_root², always the floor remainder.
- out_tag  out  TAG_WIDTH  tag of this result.
- busy  out  1  OR of all stage valid bits.

## Operation
- STAGES = ceil(WIDTH_OUT / ITER_PER_STAGE). Each stage holds {valid, rem, root, tag}. The last stage drives the outputs directly.
- The radicand is zero-extended to 2·WIDTH_OUT bits.
- The mask starts at 1 << 2(WIDTH_OUT−1) and shifts right by 2 each iteration.
- Each iteration:
  - If rem ≥ root + mask: rem −= root + mask, then root = (root >> 1) + mask.
  - Otherwise: root = root >> 1.
- The final stage may run fewer than ITER_PER_STAGE iterations. Total iterations always equal WIDTH_OUT.
- All intermediate arithmetic is 2·WIDTH_OUT bits wide. No overflow is possible.
- ROUND=1: out_root = floor_root + 1 when rem > floor_root, saturating at 2^WIDTH_OUT − 1. This is applied in the last stage.
- Advance rules:
  - Stage k loads when it is empty or stage k+1 loads.
  - The last stage loads when it is empty or out_ready is high.
  - in_ready = stage 0 can load. This is a combinational chain from out_ready.
- A transfer happens on valid & ready. A stage that does not load holds its contents, valid included.
- A bubble is filled as soon as its neighbour upstream is valid. Throughput is one result per cycle while out_ready is high.
- Results emerge in acceptance order. No operand is dropped or duplicated.

## Timing
- Latency from accept (in_valid & in_ready at edge n) to out_valid is STAGES cycles (at edge n + STAGES − 1 registered output), provided no stall occurs.
- Reset (rst_n low):
  - Immediate, asynchronous.
  - All valid bits, rem, root, tag and outputs are 0. busy = 0.
  - in_ready = 0 while rst_n is low. in_ready = 1 on the first cycle after release.
- Reset mid-operation discards all in-flight operands. Nothing from before reset is ever emitted.
- Full pipe with out_ready = 0: in_ready = 0, and all outputs hold stable until accepted.
- Full pipe with out_ready = 1 and in_valid = 1: output retires and input is accepted in the same cycle.
- out_valid must not depend combinationally on out_ready. Data is stable while out_valid & !out_ready.

## Structure
- Package sqrt_pkg holds:
  - the stages function, ceil(WIDTH_OUT / ITER_PER_STAGE);
  - the initial-mask constant function;
  - the ROUND mode constants.
- Sub-module sqrt_stage:
  - parameters: iterations, start-mask index, widths;
  - contents: combinational iteration chain plus a load-enabled register with async-reset valid;
  - instantiated STAGES times in a generate loop.
- The last instance adds rounding and saturation.

## Test plan
- Reset: hold rst_n low 3 cycles, then release → out_valid=0, out_root=0, out_rem=0, busy=0; in_ready=1 on the first cycle after release.
- Defaults, out_ready=1: back-to-back radicands 0, 1, 2, 3, 4, 50000, 65535 with tags 0–6 → roots 0, 1, 1, 1, 2, 223, 255 and rems 0, 0, 1, 2, 0, 271, 510. Tags match, latency 8, one result per cycle.
- Backpressure: out_ready=0 while 12 operands are offered → exactly 8 accepted, in_ready=0 thereafter. Then toggle out_ready randomly → all 12 retire in order, none lost or duplicated, and outputs are stable while stalled.
- WIDTH_IN=17, ITER_PER_STAGE=4 → STAGES=3 and latency 3; radicand 131071 → root 362, rem 27. ITER_PER_STAGE=9 → latency 1, same result.
- ROUND=1: 8 → root 3, rem 4; 6 → root 2, rem 2; 65535 → root 255 (saturated), rem 510.
- Async reset with 3 operands in flight → out_valid drops without a clock edge; after release no stale results appear, and the next operand 9 → root 3 at normal latency.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined square root.
package sqrt_pkg;

    localparam int unsigned RoundFloor   = 0;
    localparam int unsigned RoundNearest = 1;

    function automatic int unsigned num_stages(input int unsigned width_out,
                                               input int unsigned iter_per_stage);
        return (width_out + iter_per_stage - 1) / iter_per_stage;
    endfunction

    // Iterations in stage k; the final stage may be short.
    function automatic int unsigned stage_iters(input int unsigned width_out,
                                                input int unsigned iter_per_stage,
                                                input int unsigned k);
        int unsigned left;
        left = width_out - k * iter_per_stage;
        return (left < iter_per_stage) ? left : iter_per_stage;
    endfunction

    // Bit position of the trial mask for a given global iteration index.
    function automatic int unsigned mask_shift(input int unsigned width_out,
                                               input int unsigned iter);
        return 2 * (width_out - 1 - iter);
    endfunction

endpackage

// File: rtl/sqrt_stage.sv
// One pipeline stage: a chain of restoring square-root iterations feeding a
// load-enabled register. The last stage optionally rounds the root.
module sqrt_stage
    import sqrt_pkg::*;
#(
    parameter int unsigned WidthOut  = 8,
    parameter int unsigned TagWidth  = 4,
    parameter int unsigned StartIter = 0,
    parameter int unsigned Iters     = 1,
    parameter bit          IsLast    = 1'b0,
    parameter int unsigned RoundMode = RoundFloor
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  valid_i,
    input  logic [2*WidthOut-1:0] rem_i,
    input  logic [2*WidthOut-1:0] root_i,
    input  logic [TagWidth-1:0]   tag_i,
    output logic                  valid_o,
    output logic [2*WidthOut-1:0] rem_o,
    output logic [2*WidthOut-1:0] root_o,
    output logic [TagWidth-1:0]   tag_o
);

    localparam int unsigned W2 = 2 * WidthOut;
    localparam logic [W2-1:0] MaxRoot = {{WidthOut{1'b0}}, {WidthOut{1'b1}}};

    logic [W2-1:0] rem_c, root_c, root_rnd, mask, trial;
    logic          valid_q;
    logic [W2-1:0] rem_q, root_q;
    logic [TagWidth-1:0] tag_q;

    always_comb begin
        rem_c  = rem_i;
        root_c = root_i;
        mask   = '0;
        trial  = '0;
        for (int unsigned j = 0; j < Iters; j++) begin
            mask  = W2'(1) << mask_shift(WidthOut, StartIter + j);
            trial = root_c + mask;
            if (rem_c >= trial) begin
                rem_c  = rem_c - trial;
                root_c = (root_c >> 1) + mask;
            end else begin
                root_c = root_c >> 1;
            end
        end
    end

    // Round up when the true root is at least floor + 0.5, i.e. rem > floor.
    always_comb begin
        root_rnd = root_c;
        if (IsLast && (RoundMode == RoundNearest) && (rem_c > root_c) && (root_c != MaxRoot)) begin
            root_rnd = root_c + W2'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            rem_q   <= '0;
            root_q  <= '0;
            tag_q   <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                rem_q  <= rem_c;
                root_q <= root_rnd;
                tag_q  <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign rem_o   = rem_q;
    assign root_o  = root_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/sqrt_pipe_hs.sv
// Fully pipelined unsigned integer square root with valid/ready on both sides,
// a sideband tag, floor remainder and optional round-to-nearest root.
module sqrt_pipe_hs
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH_IN       = 16,
    parameter int unsigned WIDTH_OUT      = WIDTH_IN / 2 + WIDTH_IN % 2,
    parameter int unsigned ITER_PER_STAGE = 1,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned ROUND          = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH_IN-1:0]  in_radicand_i,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH_OUT-1:0] out_root_o,
    output logic [WIDTH_OUT:0]   out_rem_o,
    output logic [TAG_WIDTH-1:0] out_tag_o,
    output logic                 busy_o
);

    localparam int unsigned Stages = num_stages(WIDTH_OUT, ITER_PER_STAGE);
    localparam int unsigned W2     = 2 * WIDTH_OUT;

    // Index k is the input of stage k; index k+1 is its registered output.
    logic                 valid [Stages+1];
    logic [W2-1:0]        rem   [Stages+1];
    logic [W2-1:0]        root  [Stages+1];
    logic [TAG_WIDTH-1:0] tag   [Stages+1];
    logic [Stages-1:0]    load;
    logic                 unused_hi;

    assign valid[0] = in_valid_i;
    assign rem[0]   = W2'(in_radicand_i);
    assign root[0]  = '0;
    assign tag[0]   = in_tag_i;

    // A stage loads when empty or when its successor takes its contents.
    always_comb begin
        load           = '0;
        load[Stages-1] = !valid[Stages] || out_ready_i;
        for (int k = int'(Stages) - 2; k >= 0; k--) begin
            load[k] = !valid[k+1] || load[k+1];
        end
    end

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        sqrt_stage #(
            .WidthOut  (WIDTH_OUT),
            .TagWidth  (TAG_WIDTH),
            .StartIter (k * ITER_PER_STAGE),
            .Iters     (stage_iters(WIDTH_OUT, ITER_PER_STAGE, k)),
            .IsLast    (k == int'(Stages) - 1),
            .RoundMode (ROUND)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (load[k]),
            .valid_i (valid[k]),
            .rem_i   (rem[k]),
            .root_i  (root[k]),
            .tag_i   (tag[k]),
            .valid_o (valid[k+1]),
            .rem_o   (rem[k+1]),
            .root_o  (root[k+1]),
            .tag_o   (tag[k+1])
        );
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 1; k <= int'(Stages); k++) begin
            busy_o = busy_o | valid[k];
        end
    end

    assign in_ready_o  = load[0] && rst_ni;
    assign out_valid_o = valid[Stages];
    assign out_root_o  = root[Stages][WIDTH_OUT-1:0];
    assign out_rem_o   = rem[Stages][WIDTH_OUT:0];
    assign out_tag_o   = tag[Stages];

    // Upper bits of the last stage are always zero by construction.
    assign unused_hi = ^{rem[Stages], root[Stages]};

endmodule

// File: tb/tb_sqrt_pipe_hs.sv
// Self-checking bench: directed and random operands against an arithmetic
// square-root model, with backpressure, reset and parameter variants.
module tb_sqrt_pipe_hs;

    logic clk, rst_n;

    // Main DUT: defaults (WIDTH_IN=16, 8 stages).
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_rad;
    logic [3:0]  a_tag, a_otag;
    logic [7:0]  a_root;
    logic [8:0]  a_rem;

    // Variants: B = 17b/4 per stage, C = 17b/9 per stage, D = 16b round.
    logic        b_vld, b_rdy, b_ov, b_busy, c_vld, c_rdy, c_ov, c_busy;
    logic        d_vld, d_rdy, d_ov, d_busy;
    logic [16:0] b_rad, c_rad;
    logic [15:0] d_rad;
    logic [8:0]  b_root, c_root;
    logic [9:0]  b_rem, c_rem;
    logic [7:0]  d_root;
    logic [8:0]  d_rem;
    logic [3:0]  b_otag, c_otag, d_otag;

    sqrt_pipe_hs #(.WIDTH_IN(16), .ITER_PER_STAGE(1), .TAG_WIDTH(4), .ROUND(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_radicand_i(a_rad), .in_tag_i(a_tag), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .out_root_o(a_root), .out_rem_o(a_rem),
        .out_tag_o(a_otag), .busy_o(a_busy)
    );
    sqrt_pipe_hs #(.WIDTH_IN(17), .ITER_PER_STAGE(4), .TAG_WIDTH(4), .ROUND(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_vld), .in_ready_o(b_rdy),
        .in_radicand_i(b_rad), .in_tag_i(4'hb), .out_valid_o(b_ov), .out_ready_i(1'b1),
        .out_root_o(b_root), .out_rem_o(b_rem), .out_tag_o(b_otag), .busy_o(b_busy)
    );
    sqrt_pipe_hs #(.WIDTH_IN(17), .ITER_PER_STAGE(9), .TAG_WIDTH(4), .ROUND(0)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(c_vld), .in_ready_o(c_rdy),
        .in_radicand_i(c_rad), .in_tag_i(4'hc), .out_valid_o(c_ov), .out_ready_i(1'b1),
        .out_root_o(c_root), .out_rem_o(c_rem), .out_tag_o(c_otag), .busy_o(c_busy)
    );
    sqrt_pipe_hs #(.WIDTH_IN(16), .ITER_PER_STAGE(1), .TAG_WIDTH(4), .ROUND(1)) u_dut_d (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(d_vld), .in_ready_o(d_rdy),
        .in_radicand_i(d_rad), .in_tag_i(4'hd), .out_valid_o(d_ov), .out_ready_i(1'b1),
        .out_root_o(d_root), .out_rem_o(d_rem), .out_tag_o(d_otag), .busy_o(d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  root;
        logic [8:0]  rem;
        logic [3:0]  tag;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0, n_acc = 0, n_ret = 0, cyc = 0;
    bit   check_lat = 1'b0;

    function automatic longint isqrt(input longint n);
        longint r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // One clock of the main DUT: sample handshakes 1 ns after the falling edge,
    // score retirements and stalls, record accepts, then wait for the next fall.
    task automatic step();
        exp_t e;
        #1;
        if (a_out_valid && a_out_ready) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL a_spurious: observed result root %0d expected none", a_root);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("a_root", 32'(a_root), 32'(e.root));
                chk("a_rem", 32'(a_rem), 32'(e.rem));
                chk("a_tag", 32'(a_otag), 32'(e.tag));
                if (check_lat) chk("a_latency", 32'(cyc) - e.cyc, 32'd8);
                n_ret++;
            end
        end else if (a_out_valid && q.size() != 0) begin
            chk("a_stall_root", 32'(a_root), 32'(q[0].root));
            chk("a_stall_rem", 32'(a_rem), 32'(q[0].rem));
            chk("a_stall_tag", 32'(a_otag), 32'(q[0].tag));
        end
        if (a_in_valid && a_in_ready) begin
            e.root = 8'(isqrt(longint'(a_rad)));
            e.rem  = 9'(longint'(a_rad) - isqrt(longint'(a_rad)) ** 2);
            e.tag  = a_tag;
            e.cyc  = 32'(cyc);
            q.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Single operand through a variant DUT; measures latency in clock cycles.
    task automatic aux_op(input int which, input logic [16:0] rad, input int exp_lat);
        logic rdy, v;
        logic [8:0] r;
        logic [9:0] m;
        logic [3:0] t, et;
        int lat;
        longint er, em;
        case (which)
            0: begin b_vld = 1'b1; b_rad = rad; end
            1: begin c_vld = 1'b1; c_rad = rad; end
            default: begin d_vld = 1'b1; d_rad = rad[15:0]; end
        endcase
        #1;
        rdy = (which == 0) ? b_rdy : (which == 1) ? c_rdy : d_rdy;
        chk("aux_in_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        b_vld = 1'b0; c_vld = 1'b0; d_vld = 1'b0;
        lat = 0; v = 1'b0; r = '0; m = '0; t = '0;
        while (!v && lat < 20) begin
            lat++;
            #1;
            case (which)
                0: begin v = b_ov; r = b_root; m = b_rem; t = b_otag; end
                1: begin v = c_ov; r = c_root; m = c_rem; t = c_otag; end
                default: begin v = d_ov; r = {1'b0, d_root}; m = {1'b0, d_rem}; t = d_otag; end
            endcase
            if (!v) @(negedge clk);
        end
        er = isqrt(longint'(rad));
        em = longint'(rad) - er * er;
        if (which == 2 && em > er && er < 255) er++;
        et = (which == 0) ? 4'hb : (which == 1) ? 4'hc : 4'hd;
        chk("aux_valid", 32'(v), 32'd1);
        chk("aux_latency", 32'(lat), 32'(exp_lat));
        chk("aux_root", 32'(r), 32'(er));
        chk("aux_rem", 32'(m), 32'(em));
        chk("aux_tag", 32'(t), 32'(et));
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] dir_rad [7];
        logic [15:0] bp_rad [12];
        int acc0, ret0, idx, sent;

        dir_rad = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd50000, 16'd65535};
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_rad = '0; a_tag = '0;
        b_vld = 1'b0; c_vld = 1'b0; d_vld = 1'b0;
        b_rad = '0; c_rad = '0; d_rad = '0;

        // Reset held for three cycles.
        #1;
        chk("rst_in_ready_low", 32'(a_in_ready), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(a_in_ready), 32'd1);
        chk("rel_out_valid", 32'(a_out_valid), 32'd0);
        chk("rel_out_root", 32'(a_root), 32'd0);
        chk("rel_out_rem", 32'(a_rem), 32'd0);
        chk("rel_busy", 32'(a_busy), 32'd0);
        @(negedge clk);

        // Directed back-to-back stream, full throughput, latency 8.
        check_lat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1; a_rad = dir_rad[i]; a_tag = 4'(i);
            step();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        chk("dir_drained", 32'(q.size()), 32'd0);
        chk("dir_accepted", 32'(n_acc), 32'd7);
        check_lat = 1'b0;

        // Backpressure: 12 offered while the consumer stalls.
        for (int i = 0; i < 12; i++) bp_rad[i] = 16'($urandom);
        a_out_ready = 1'b0;
        acc0 = n_acc; ret0 = n_ret; idx = 0;
        a_in_valid = 1'b1; a_rad = bp_rad[0]; a_tag = 4'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (n_acc != acc0 + idx && idx < 11) begin
                idx++; a_rad = bp_rad[idx]; a_tag = 4'(idx);
            end
        end
        chk("bp_accepted", 32'(n_acc - acc0), 32'd8);
        #1;
        chk("bp_in_ready_full", 32'(a_in_ready), 32'd0);
        chk("bp_out_valid_held", 32'(a_out_valid), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 400 && (n_acc - acc0 < 12 || q.size() != 0); i++) begin
            a_out_ready = ($urandom_range(1, 0) != 0);
            a_in_valid  = (n_acc - acc0 < 12);
            step();
            if (n_acc - acc0 > idx && idx < 11) begin
                idx++; a_rad = bp_rad[idx]; a_tag = 4'(idx);
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("bp_total_accepted", 32'(n_acc - acc0), 32'd12);
        chk("bp_retired", 32'(n_ret - ret0), 32'd12);

        // Random stream with random gaps and stalls.
        sent = 0; ret0 = n_ret;
        for (int i = 0; i < 3000 && (sent < 200 || q.size() != 0); i++) begin
            if (!a_in_valid && sent < 200 && $urandom_range(3, 0) != 0) begin
                a_in_valid = 1'b1; a_rad = 16'($urandom); a_tag = 4'($urandom);
            end
            a_out_ready = ($urandom_range(2, 0) != 0);
            acc0 = n_acc;
            step();
            if (n_acc != acc0) begin
                sent++; a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("rnd_retired", 32'(n_ret - ret0), 32'd200);

        // Parameter variants and rounding.
        aux_op(0, 17'd131071, 3);
        aux_op(1, 17'd131071, 1);
        aux_op(0, 17'($urandom), 3);
        aux_op(2, 17'd8, 8);
        aux_op(2, 17'd6, 8);
        aux_op(2, 17'd65535, 8);

        // Asynchronous reset with three operands in flight, output stalled.
        a_out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 10 && n_acc - acc0 < 3; i++) begin
            a_in_valid = 1'b1; a_rad = 16'(1000 + n_acc - acc0); a_tag = 4'(n_acc - acc0);
            step();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 20 && !a_out_valid; i++) step();
        chk("inflight_out_valid", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(a_out_valid), 32'd0);
        chk("async_busy", 32'(a_busy), 32'd0);
        chk("async_in_ready", 32'(a_in_ready), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        check_lat = 1'b1;
        ret0 = n_ret;
        a_in_valid = 1'b1; a_rad = 16'd9; a_tag = 4'd9;
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("post_reset_retired", 32'(n_ret - ret0), 32'd1);
        chk("post_reset_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
